// File: rtl/music_pkg.sv
// Shared music-player definitions: sequencer states, score ROM word layout and field codes.
// Used by score_sequencer (SCORE_SEQUENCER_LOOP_EN selects looping playback there).
package music_pkg;

    localparam int unsigned SEQ_ADDR_BITS = 6;
    localparam int unsigned SEQ_NOTE_BITS = 5;
    localparam int unsigned SEQ_DUR_BITS  = 4;

    // ROM word is {note, dur}, note in the MSBs
    localparam int unsigned DUR_LSB   = 0;
    localparam int unsigned NOTE_LSB  = DUR_LSB + SEQ_DUR_BITS;
    localparam int unsigned WORD_BITS = SEQ_NOTE_BITS + SEQ_DUR_BITS;

    localparam logic [SEQ_NOTE_BITS-1:0] NOTE_REST = '0;
    localparam logic [SEQ_DUR_BITS-1:0]  DUR_END   = '0;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StHold,
        StDone
    } seq_state_e;

endpackage

// File: rtl/score_sequencer_if.sv
// Beat/control inputs, score ROM port and note outputs of the score sequencer.
// Widths default to the music_pkg score layout.
interface score_sequencer_if #(
    parameter int unsigned ADDR_BITS = music_pkg::SEQ_ADDR_BITS,
    parameter int unsigned NOTE_BITS = music_pkg::SEQ_NOTE_BITS,
    parameter int unsigned DUR_BITS  = music_pkg::SEQ_DUR_BITS
);

    logic                          beat;
    logic                          play;
    logic                          restart;
    logic [ADDR_BITS-1:0]          rom_addr;
    logic [NOTE_BITS+DUR_BITS-1:0] rom_data;
    logic [NOTE_BITS-1:0]          note;
    logic                          note_valid;
    logic                          busy;
    logic                          done;

    modport master (
        output beat, play, restart, rom_data,
        input  rom_addr, note, note_valid, busy, done
    );

    modport slave (
        input  beat, play, restart, rom_data,
        output rom_addr, note, note_valid, busy, done
    );

endinterface

// File: rtl/score_sequencer.sv
// Steps through a score ROM on beat pulses, holding each note for its encoded beat count.
// Define SCORE_SEQUENCER_LOOP_EN to restart from address 0 at end-of-score instead of stopping.
module score_sequencer
    import music_pkg::*;
#(
    parameter int unsigned ADDR_BITS = SEQ_ADDR_BITS,
    parameter int unsigned NOTE_BITS = SEQ_NOTE_BITS,
    parameter int unsigned DUR_BITS  = SEQ_DUR_BITS
) (
    input  logic              clk,
    input  logic              rst_n,
    score_sequencer_if.slave  bus
);

`ifdef SCORE_SEQUENCER_LOOP_EN
    localparam seq_state_e EndState = StFetch;
`else
    localparam seq_state_e EndState = StDone;
`endif

    seq_state_e           state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [DUR_BITS-1:0]  cnt_q, cnt_d;
    logic [NOTE_BITS-1:0] note_q, note_d;
    logic                 valid_q, valid_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;

    logic [NOTE_BITS-1:0] data_note;
    logic [DUR_BITS-1:0]  data_dur;
    logic                 data_end;
    logic                 last_addr;
    logic                 terminal;
    logic                 eos;

    assign data_note = bus.rom_data[DUR_LSB + DUR_BITS +: NOTE_BITS];
    assign data_dur  = bus.rom_data[DUR_LSB +: DUR_BITS];
    assign data_end  = (data_dur == DUR_BITS'(DUR_END));
    assign last_addr = &addr_q;
    // beat_cnt never drops below 1, so a count of 1 (or the cleared 0) marks the last beat
    assign terminal  = bus.beat && bus.play && (cnt_q <= DUR_BITS'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            cnt_q   <= '0;
            note_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            note_q  <= note_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.restart) begin
            state_d = bus.play ? StFetch : StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (bus.play) state_d = StFetch;
                StFetch: state_d = StLoad;
                StLoad:  state_d = data_end ? EndState : StHold;
                StHold:  if (terminal) state_d = last_addr ? EndState : StFetch;
                StDone:  state_d = StDone;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        note_d  = note_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        eos     = 1'b0;
        if (bus.restart) begin
            addr_d  = '0;
            cnt_d   = '0;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                StLoad: begin
                    if (data_end) begin
                        eos = 1'b1;
                    end else begin
                        note_d  = data_note;
                        cnt_d   = data_dur;
                        valid_d = bus.play && (data_note != NOTE_BITS'(NOTE_REST));
                    end
                end
                StHold: begin
                    if (!bus.play) begin
                        valid_d = 1'b0;
                    end else begin
                        valid_d = (note_q != NOTE_BITS'(NOTE_REST));
                        if (bus.beat) begin
                            if (!terminal) begin
                                cnt_d = cnt_q - DUR_BITS'(1);
                            end else if (last_addr) begin
                                eos = 1'b1;
                            end else begin
                                addr_d = addr_q + ADDR_BITS'(1);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
        if (eos) begin
            done_d  = 1'b1;
            valid_d = 1'b0;
`ifdef SCORE_SEQUENCER_LOOP_EN
            addr_d  = '0;
`endif
        end
        busy_d = (state_d != StIdle) && (state_d != StDone);
    end

    assign bus.rom_addr   = addr_q;
    assign bus.note       = note_q;
    assign bus.note_valid = valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_score_sequencer.sv
// Self-checking bench for score_sequencer with a behavioural score ROM and beat-level model.
// Loop-mode expectations apply when SCORE_SEQUENCER_LOOP_EN is defined.
module tb_score_sequencer;
    import music_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    logic [8:0] rom [64];
    int         sc_note [64];
    int         sc_dur [64];

    always #5 clk = ~clk;

    score_sequencer_if bus_if ();

    score_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    // Synchronous score ROM: data valid one cycle after the address
    always @(posedge clk) bus_if.rom_data <= rom[bus_if.rom_addr];

`ifdef SCORE_SEQUENCER_LOOP_EN
    localparam logic BusyAfterEnd = 1'b1;
`else
    localparam logic BusyAfterEnd = 1'b0;
`endif

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_rom(input int n);
        for (int i = 0; i < 64; i++) rom[i] = 9'd0;
        for (int i = 0; i < n; i++) rom[i] = {5'(sc_note[i]), 4'(sc_dur[i])};
    endtask

    task automatic go_idle();
        bus_if.play    = 1'b0;
        bus_if.beat    = 1'b0;
        bus_if.restart = 1'b1;
        cyc(1);
        bus_if.restart = 1'b0;
        cyc(1);
    endtask

    task automatic check_zero_outputs(input string tag);
        vectors++;
        if (bus_if.rom_addr !== 6'd0 || bus_if.note !== 5'd0 || bus_if.note_valid !== 1'b0 ||
            bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: addr=%0d note=%0d valid=%b busy=%b done=%b, want all zero",
                     tag, bus_if.rom_addr, bus_if.note, bus_if.note_valid, bus_if.busy,
                     bus_if.done);
        end
    endtask

    // Plays sc_* entries [0,n) with play held high; each beat maps to an entry by cumulative
    // duration, and done follows the last beat by the refetch latency.
    task automatic run_score(input int n, input int period, input string tag);
        int exp_q[$];
        int lat;
        int last_note;
        int e;
        for (int i = 0; i < n; i++)
            for (int d = 0; d < sc_dur[i]; d++) exp_q.push_back(sc_note[i]);
        lat = (n == 64) ? 1 : 3;
        last_note = exp_q[exp_q.size() - 1];
        go_idle();
        load_rom(n);
        bus_if.play = 1'b1;
        cyc(period);
        for (int k = 0; k < exp_q.size(); k++) begin
            e = exp_q[k];
            bus_if.beat = 1'b1;
            vectors++;
            if (bus_if.note !== 5'(e) || bus_if.note_valid !== (e != 0)) begin
                miscompares++;
                $display("FAIL %s beat %0d: note=%0d valid=%b, want %0d/%b", tag, k,
                         bus_if.note, bus_if.note_valid, e, (e != 0));
            end
            vectors++;
            if (bus_if.busy !== 1'b1 || bus_if.done !== 1'b0) begin
                miscompares++;
                $display("FAIL %s beat %0d: busy=%b done=%b, want 1/0", tag, k,
                         bus_if.busy, bus_if.done);
            end
            cyc(1);
            bus_if.beat = 1'b0;
            if (k != exp_q.size() - 1) cyc(period - 1);
        end
        for (int j = 1; j <= 4; j++) begin
            vectors++;
            if (bus_if.done !== (j == lat)) begin
                miscompares++;
                $display("FAIL %s done t+%0d: got %b, want %b", tag, j, bus_if.done, (j == lat));
            end
            if (j < lat) begin
                vectors++;
                if (bus_if.note !== 5'(last_note) || bus_if.note_valid !== (last_note != 0)) begin
                    miscompares++;
                    $display("FAIL %s hold t+%0d: note=%0d valid=%b, want %0d/%b", tag, j,
                             bus_if.note, bus_if.note_valid, last_note, (last_note != 0));
                end
            end
            if (j == lat) begin
                vectors++;
                if (bus_if.note_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s valid on done: got %b, want 0", tag, bus_if.note_valid);
                end
            end
            if (j == lat + 1) begin
                vectors++;
                if (bus_if.busy !== BusyAfterEnd) begin
                    miscompares++;
                    $display("FAIL %s busy after end: got %b, want %b", tag, bus_if.busy,
                             BusyAfterEnd);
                end
            end
            cyc(1);
        end
        bus_if.play = 1'b0;
        cyc(1);
    endtask

    task automatic test_reset();
        check_zero_outputs("reset_initial");
        rst_n = 1'b1;
        sc_note[0] = 5; sc_dur[0] = 1;
        sc_note[1] = 8; sc_dur[1] = 4;
        go_idle();
        load_rom(2);
        bus_if.play = 1'b1;
        cyc(8);
        bus_if.beat = 1'b1;
        cyc(1);
        bus_if.beat = 1'b0;
        cyc(6);
        vectors++;
        if (bus_if.rom_addr !== 6'd1 || bus_if.note !== 5'd8 || bus_if.note_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_setup: addr=%0d note=%0d valid=%b, want 1/8/1",
                     bus_if.rom_addr, bus_if.note, bus_if.note_valid);
        end
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("reset_async");
        @(negedge clk);
        bus_if.play = 1'b0;
        rst_n = 1'b1;
        cyc(3);
        check_zero_outputs("reset_idle");
        bus_if.play = 1'b1;
        cyc(3);
        vectors++;
        if (bus_if.rom_addr !== 6'd0 || bus_if.note !== 5'd5 || bus_if.note_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_replay: addr=%0d note=%0d valid=%b, want 0/5/1",
                     bus_if.rom_addr, bus_if.note, bus_if.note_valid);
        end
        bus_if.play = 1'b0;
    endtask

    task automatic test_basic();
        sc_note[0] = 5; sc_dur[0] = 2;
        sc_note[1] = 9; sc_dur[1] = 1;
        run_score(2, 16, "basic");
    endtask

    task automatic test_rest();
        sc_note[0] = 0; sc_dur[0] = 3;
        run_score(1, 10, "rest");
    endtask

    task automatic test_pause();
        sc_note[0] = 7; sc_dur[0] = 3;
        sc_note[1] = 4; sc_dur[1] = 1;
        go_idle();
        load_rom(2);
        bus_if.play = 1'b1;
        cyc(8);
        bus_if.beat = 1'b1;
        cyc(1);
        bus_if.beat = 1'b0;
        cyc(2);
        bus_if.play = 1'b0;
        cyc(2);
        for (int i = 0; i < 4; i++) begin
            bus_if.beat = 1'b1;
            vectors++;
            if (bus_if.note_valid !== 1'b0 || bus_if.rom_addr !== 6'd0) begin
                miscompares++;
                $display("FAIL pause beat %0d: valid=%b addr=%0d, want 0/0", i,
                         bus_if.note_valid, bus_if.rom_addr);
            end
            cyc(1);
            bus_if.beat = 1'b0;
            cyc(3);
        end
        bus_if.play = 1'b1;
        cyc(2);
        vectors++;
        if (bus_if.note !== 5'd7 || bus_if.note_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL pause resume: note=%0d valid=%b, want 7/1", bus_if.note,
                     bus_if.note_valid);
        end
        bus_if.beat = 1'b1;
        cyc(1);
        bus_if.beat = 1'b0;
        cyc(1);
        vectors++;
        if (bus_if.rom_addr !== 6'd0) begin
            miscompares++;
            $display("FAIL pause second beat: addr=%0d, want 0", bus_if.rom_addr);
        end
        cyc(4);
        bus_if.beat = 1'b1;
        cyc(1);
        bus_if.beat = 1'b0;
        vectors++;
        if (bus_if.rom_addr !== 6'd1) begin
            miscompares++;
            $display("FAIL pause third beat: addr=%0d, want 1", bus_if.rom_addr);
        end
        cyc(2);
        vectors++;
        if (bus_if.note !== 5'd4 || bus_if.note_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL pause next note: note=%0d valid=%b, want 4/1", bus_if.note,
                     bus_if.note_valid);
        end
        bus_if.play = 1'b0;
    endtask

    task automatic test_restart();
        sc_note[0] = 3; sc_dur[0] = 1;
        sc_note[1] = 6; sc_dur[1] = 2;
        go_idle();
        load_rom(2);
        bus_if.play = 1'b1;
        cyc(8);
        for (int b = 0; b < 2; b++) begin
            bus_if.beat = 1'b1;
            cyc(1);
            bus_if.beat = 1'b0;
            cyc(7);
        end
        bus_if.beat = 1'b1;
        bus_if.restart = 1'b1;
        cyc(1);
        bus_if.beat = 1'b0;
        bus_if.restart = 1'b0;
        for (int j = 1; j <= 6; j++) begin
            vectors++;
            if (bus_if.done !== 1'b0) begin
                miscompares++;
                $display("FAIL restart done t+%0d: got %b, want 0", j, bus_if.done);
            end
            if (j == 1) begin
                vectors++;
                if (bus_if.rom_addr !== 6'd0 || bus_if.note_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL restart t+1: addr=%0d valid=%b, want 0/0", bus_if.rom_addr,
                             bus_if.note_valid);
                end
            end
            if (j == 3) begin
                vectors++;
                if (bus_if.note !== 5'd3 || bus_if.note_valid !== 1'b1) begin
                    miscompares++;
                    $display("FAIL restart reload: note=%0d valid=%b, want 3/1", bus_if.note,
                             bus_if.note_valid);
                end
            end
            cyc(1);
        end
        bus_if.play = 1'b0;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 64; i++) begin
            sc_note[i] = 1 + (i % 31);
            sc_dur[i]  = 1;
        end
        run_score(64, 6, "wrap");
    endtask

    task automatic test_random();
        int n;
        int period;
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(1, 6);
            period = $urandom_range(6, 12);
            for (int i = 0; i < n; i++) begin
                sc_note[i] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 31);
                sc_dur[i]  = $urandom_range(1, 4);
            end
            run_score(n, period, "random");
        end
    endtask

`ifdef SCORE_SEQUENCER_LOOP_EN
    task automatic test_loop();
        int seq_q[$];
        int beat_idx;
        int done_cnt;
        seq_q = '{11, 13, 13};
        sc_note[0] = 11; sc_dur[0] = 1;
        sc_note[1] = 13; sc_dur[1] = 2;
        go_idle();
        load_rom(2);
        bus_if.play = 1'b1;
        beat_idx = 0;
        done_cnt = 0;
        for (int c = 1; c <= 66; c++) begin
            bus_if.beat = (c % 10 == 0) && (beat_idx < 6);
            if (bus_if.beat) begin
                vectors++;
                if (bus_if.note !== 5'(seq_q[beat_idx % 3]) || bus_if.note_valid !== 1'b1) begin
                    miscompares++;
                    $display("FAIL loop beat %0d: note=%0d valid=%b, want %0d/1", beat_idx,
                             bus_if.note, bus_if.note_valid, seq_q[beat_idx % 3]);
                end
                beat_idx++;
            end
            if (bus_if.done === 1'b1) begin
                done_cnt++;
                vectors++;
                if (bus_if.rom_addr !== 6'd0 || bus_if.busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL loop wrap: addr=%0d busy=%b, want 0/1", bus_if.rom_addr,
                             bus_if.busy);
                end
            end
            cyc(1);
        end
        bus_if.beat = 1'b0;
        vectors++;
        if (done_cnt != 2) begin
            miscompares++;
            $display("FAIL loop done count: got %0d, want 2", done_cnt);
        end
        bus_if.play = 1'b0;
    endtask
`endif

    initial begin
        bus_if.beat    = 1'b0;
        bus_if.play    = 1'b0;
        bus_if.restart = 1'b0;
        for (int i = 0; i < 64; i++) rom[i] = 9'd0;
        cyc(2);
        test_reset();
        test_basic();
        test_rest();
        test_pause();
        test_restart();
        test_wrap();
        test_random();
`ifdef SCORE_SEQUENCER_LOOP_EN
        test_loop();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
